// File: rtl/uart_tx_fifo_sequencer_if.sv
// FIFO read port and transmitter load handshake between the TX sequencer and its neighbours.
interface uart_tx_fifo_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_read_n;
  logic                  tx_ready;
  logic                  tx_load;
  logic [DATA_WIDTH-1:0] tx_data;

  modport master (
    input  fifo_empty, fifo_data, tx_ready,
    output fifo_read_n, tx_load, tx_data
  );

  modport slave (
    output fifo_empty, fifo_data, tx_ready,
    input  fifo_read_n, tx_load, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo_sequencer.sv
// Sole reader of the UART TX FIFO: strobes a read, waits out the FIFO read latency,
// captures the byte and hands it to the transmitter; flush drains without sending.
module uart_tx_fifo_sequencer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   clr_count,
  uart_tx_fifo_sequencer_if.master bus,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   sent_count
);

  localparam int unsigned WAIT_W    = 2;
  // WAIT lasts READ_LATENCY-1 cycles; the down-counter is loaded with one less than that
  localparam int unsigned WAIT_LOAD = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    CAP  = 3'd3,
    SEND = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  load_c;

  // State and latency counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next-state and combinational load decision; flush beats tx_ready in SEND
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    load_c    = 1'b0;
    case (state)
      IDLE: begin
        if ((enable | flush) & ~bus.fifo_empty) state_nxt = RD;
      end
      RD: begin
        if (READ_LATENCY > 1) begin
          state_nxt = WAIT;
          wait_nxt  = WAIT_W'(WAIT_LOAD);
        end else begin
          state_nxt = CAP;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) state_nxt = CAP;
        else                wait_nxt  = wait_cnt - WAIT_W'(1);
      end
      CAP: begin
        state_nxt = flush ? IDLE : SEND;
      end
      SEND: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (bus.tx_ready) begin
          load_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.tx_load = load_c;
  assign bus.tx_data = hold_q;

  // Registered strobes derived from the upcoming state so they align with it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.fifo_read_n <= 1'b1;
      busy            <= 1'b0;
    end else begin
      bus.fifo_read_n <= (state_nxt != RD);
      busy            <= (state_nxt != IDLE);
    end
  end

  // Capture register: FIFO data is valid during CAP, even if the byte is then flushed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          hold_q <= '0;
    else if (state == CAP) hold_q <= bus.fifo_data;
  end

  // Transmitted-byte counter; clear wins over a coincident increment
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       sent_count <= '0;
    else if (clr_count) sent_count <= '0;
    else if (load_c)    sent_count <= sent_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_uart_tx_fifo_sequencer.sv
// Randomized and directed bench for uart_tx_fifo_sequencer with a transaction-level
// reference model, a FIFO model with registered read latency, and per-cycle compares.
`timescale 1ns/1ps
module tb_uart_tx_fifo_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned RL = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          clr_count = 1'b0;
  logic          busy;
  logic [CW-1:0] sent_count;

  uart_tx_fifo_sequencer_if #(.DATA_WIDTH(DW)) bus();

  uart_tx_fifo_sequencer #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .READ_LATENCY(RL)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .flush(flush),
    .clr_count(clr_count), .bus(bus.master), .busy(busy), .sent_count(sent_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model state
  typedef struct { logic [7:0] d; int ready; } rd_t;
  logic [7:0] fifo_q[$];
  rd_t        pipe[$];
  rd_t        ent;
  int         cyc = 0;

  // Reference model: one byte job at a time, tracked by age since its read strobe
  logic [7:0] exp_q[$];
  bit         m_busy, m_capt, m_rd_next, nxt_rd;
  int         m_age, m_cnt;
  logic [7:0] m_byte, m_hold;

  // Observation log used by the directed checks
  int         rd_pulses = 0, loads = 0, last_rd_cyc = 0, last_load_cyc = 0;
  logic [7:0] load_log[$];

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    bus.fifo_empty = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      fifo_q.delete(); pipe.delete(); exp_q.delete();
      bus.fifo_empty = 1'b1;
      m_busy = 0; m_capt = 0; m_rd_next = 0; m_age = 0; m_cnt = 0;
      m_byte = 8'h00; m_hold = 8'h00;
    end else begin
      // FIFO: data appears RL cycles after the strobe cycle, garbage otherwise
      if (pipe.size() > 0 && pipe[0].ready == cyc) begin
        bus.fifo_data = pipe[0].d;
        void'(pipe.pop_front());
      end else begin
        bus.fifo_data = 8'($urandom);
      end
      if (!bus.fifo_read_n) begin
        rd_pulses++;
        last_rd_cyc = cyc;
        check("fifo_underflow", 32'(fifo_q.size() != 0), 32'(1));
        if (fifo_q.size() > 0) begin
          ent.d = fifo_q.pop_front();
          ent.ready = cyc + int'(RL);
          pipe.push_back(ent);
        end
        bus.fifo_empty = (fifo_q.size() == 0);
      end
      if (bus.tx_load) begin
        loads++;
        last_load_cyc = cyc;
        load_log.push_back(bus.tx_data);
      end

      // Compare this cycle against the model
      check("fifo_read_n", 32'(bus.fifo_read_n), 32'(!m_rd_next));
      if (m_rd_next) begin
        check("model_rd_nonempty", 32'(exp_q.size() != 0), 32'(1));
        m_byte = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        m_busy = 1; m_capt = 0; m_age = 0;
      end
      check("busy", 32'(busy), 32'(m_busy));
      check("tx_load", 32'(bus.tx_load), 32'(m_busy && m_capt && bus.tx_ready && !flush));
      check("tx_data", 32'(bus.tx_data), 32'(m_hold));
      check("sent_count", 32'(sent_count), 32'(m_cnt));

      // Advance the model to the next cycle
      nxt_rd = 0;
      if (m_busy) begin
        if (!m_capt) begin
          if (m_age == int'(RL)) begin
            m_hold = m_byte;
            if (flush) m_busy = 0;
            else       m_capt = 1;
          end
          m_age++;
        end else if (flush) begin
          m_busy = 0;
        end else if (bus.tx_ready) begin
          m_busy = 0;
          m_cnt  = (m_cnt + 1) % (1 << CW);
        end
        if (!m_busy) m_capt = 0;
      end else begin
        nxt_rd = (enable || flush) && !bus.fifo_empty;
      end
      if (clr_count) m_cnt = 0;
      m_rd_next = nxt_rd;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(bus.fifo_empty && !busy) && n < budget);
    check(name, 32'(bus.fifo_empty && !busy), 32'(1));
  endtask

  task automatic pulse_clr();
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int rd0, ld0, lg0;

  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = 8'h00;
    bus.tx_ready   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_fifo_read_n", 32'(bus.fifo_read_n), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_tx_data", 32'(bus.tx_data), 32'(0));
    reset_n = 1'b1;
    step();

    // Single byte: load three cycles after the read strobe
    rd0 = rd_pulses; ld0 = loads;
    enable = 1'b1; bus.tx_ready = 1'b1;
    push(8'hA5);
    wait_idle(30, "single_idle");
    check("single_reads", 32'(rd_pulses - rd0), 32'(1));
    check("single_loads", 32'(loads - ld0), 32'(1));
    check("single_latency", 32'(last_load_cyc - last_rd_cyc), 32'(3));
    check("single_data", 32'(load_log[load_log.size()-1]), 32'(8'hA5));
    check("single_count", 32'(sent_count), 32'(1));

    // Backpressure on the first of three bytes
    pulse_clr();
    enable = 1'b0; bus.tx_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33);
    rd0 = rd_pulses; ld0 = loads; lg0 = load_log.size();
    enable = 1'b1;
    repeat (14) step();
    check("bp_hold_data", 32'(bus.tx_data), 32'(8'h11));
    check("bp_hold_busy", 32'(busy), 32'(1));
    check("bp_hold_noload", 32'(loads - ld0), 32'(0));
    bus.tx_ready = 1'b1;
    wait_idle(60, "bp_idle");
    check("bp_reads", 32'(rd_pulses - rd0), 32'(3));
    check("bp_loads", 32'(loads - ld0), 32'(3));
    check("bp_order0", 32'(load_log[lg0]), 32'(8'h11));
    check("bp_order1", 32'(load_log[lg0+1]), 32'(8'h22));
    check("bp_order2", 32'(load_log[lg0+2]), 32'(8'h33));
    check("bp_count", 32'(sent_count), 32'(3));

    // Flush drains four bytes without transmitting
    enable = 1'b0; bus.tx_ready = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    rd0 = rd_pulses; ld0 = loads;
    step();
    flush = 1'b1;
    wait_idle(60, "flush_idle");
    flush = 1'b0;
    check("flush_reads", 32'(rd_pulses - rd0), 32'(4));
    check("flush_loads", 32'(loads - ld0), 32'(0));
    check("flush_count", 32'(sent_count), 32'(3));

    // Asynchronous reset in the middle of SEND
    enable = 1'b1; bus.tx_ready = 1'b0;
    push(8'h5A);
    repeat (8) step();
    check("pre_rst_busy", 32'(busy), 32'(1));
    #2;
    reset_n = 1'b0;
    bus.tx_ready = 1'b1;
    #1;
    check("arst_fifo_read_n", 32'(bus.fifo_read_n), 32'(1));
    check("arst_tx_load", 32'(bus.tx_load), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_count", 32'(sent_count), 32'(0));
    check("arst_tx_data", 32'(bus.tx_data), 32'(0));
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // Enable dropped during WAIT still delivers the byte in flight
    rd0 = rd_pulses; ld0 = loads;
    enable = 1'b1; bus.tx_ready = 1'b1;
    push(8'hC3);
    step(); step();
    enable = 1'b0;
    wait_idle(30, "endrop_idle");
    check("endrop_loads", 32'(loads - ld0), 32'(1));
    check("endrop_data", 32'(load_log[load_log.size()-1]), 32'(8'hC3));
    push(8'h3C);
    repeat (10) step();
    check("endrop_no_rd", 32'(rd_pulses - rd0), 32'(1));
    check("endrop_pending", 32'(bus.fifo_empty), 32'(0));

    // Flush in SEND beats tx_ready
    ld0 = loads;
    enable = 1'b1; bus.tx_ready = 1'b0;
    repeat (8) step();
    check("fsend_busy", 32'(busy), 32'(1));
    enable = 1'b0; flush = 1'b1; bus.tx_ready = 1'b1;
    #1;
    check("fsend_no_load", 32'(bus.tx_load), 32'(0));
    step();
    flush = 1'b0;
    check("fsend_idle", 32'(busy), 32'(0));
    check("fsend_loads", 32'(loads - ld0), 32'(0));
    check("fsend_count", 32'(sent_count), 32'(1));

    // Counter wraps modulo 16 after 17 bytes
    pulse_clr();
    ld0 = loads;
    for (int i = 0; i < 17; i++) push(8'(i * 7 + 1));
    enable = 1'b1; bus.tx_ready = 1'b1;
    wait_idle(200, "wrap_idle");
    check("wrap_loads", 32'(loads - ld0), 32'(17));
    check("wrap_count", 32'(sent_count), 32'(1));

    // Clear coincident with a load leaves zero
    bus.tx_ready = 1'b0;
    push(8'h77);
    repeat (8) step();
    bus.tx_ready = 1'b1; clr_count = 1'b1;
    #1;
    check("clr_load_same", 32'(bus.tx_load), 32'(1));
    step();
    clr_count = 1'b0;
    check("clr_load_count", 32'(sent_count), 32'(0));

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 2500; i++) begin
      step();
      bus.tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 15) push(8'($urandom));
      if ($urandom_range(0, 99) < 5) enable = ~enable;
      flush     = ($urandom_range(0, 99) < 4);
      clr_count = ($urandom_range(0, 99) < 2);
    end
    flush = 1'b0; clr_count = 1'b0; enable = 1'b1; bus.tx_ready = 1'b1;
    wait_idle(4000, "rand_drain_idle");
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
